// File: rtl/adc_pkg.sv
// Shared constants, frame layout and state encoding for the ADC capture block.
package adc_pkg;

    localparam int ADC_DATA_W     = 14;
    localparam int ADC_FRAME_BITS = 34;

    // Frame bit positions, indexed in transmission order (bit 0 is first on the wire).
    localparam logic [5:0] ADC_LAST_BIT = 6'(ADC_FRAME_BITS - 1);
    localparam logic [5:0] ADC_A_FIRST  = 6'd2;
    localparam logic [5:0] ADC_A_LAST   = 6'd15;
    localparam logic [5:0] ADC_B_FIRST  = 6'd18;
    localparam logic [5:0] ADC_B_LAST   = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_t;

    // True when frame bit k falls inside the inclusive window [lo, hi].
    function automatic logic bit_in_window(input logic [5:0] k,
                                           input logic [5:0] lo,
                                           input logic [5:0] hi);
        return (k >= lo) && (k <= hi);
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SPI clock generator for the ADC frame: registered SCK, a tick marking each
// low-to-high transition, and a flag on the last cycle of the 34th high half.
module adc_sck_gen
    import adc_pkg::*;
#(
    parameter int SCK_HALF = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_sck,
    output logic       o_rise_tick,
    output logic       o_frame_end,
    output logic [5:0] o_bit_idx
);

    localparam logic [3:0] HALF_LAST = 4'(SCK_HALF - 1);

    logic [3:0] r_half_cnt;
    logic [5:0] r_bit_cnt;
    logic       r_sck;
    logic       w_half_end;

    assign w_half_end = (r_half_cnt == HALF_LAST);

    // Half-period counter toggles SCK; bit counter advances at the end of each high half.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sck      <= 1'b0;
        end else if (w_half_end) begin
            r_half_cnt <= '0;
            r_sck      <= ~r_sck;
            if (r_sck) begin
                r_bit_cnt <= (r_bit_cnt == ADC_LAST_BIT) ? 6'd0 : r_bit_cnt + 6'd1;
            end
        end else begin
            r_half_cnt <= r_half_cnt + 4'd1;
        end
    end

    // The tick is high in the cycle whose closing edge drives SCK high.
    assign o_rise_tick = i_en && w_half_end && !r_sck;
    assign o_frame_end = i_en && w_half_end && r_sck && (r_bit_cnt == ADC_LAST_BIT);
    assign o_sck       = r_sck;
    assign o_bit_idx   = r_bit_cnt;

endmodule

// File: rtl/adc_capture.sv
// Dual-channel 14-bit serial ADC capture: convert strobe, 34-bit frame readout,
// and signed channel A/B results that update only when a capture completes.
module adc_capture
    import adc_pkg::*;
#(
    parameter int SCK_HALF    = 3,
    parameter int CONV_CYCLES = 2
) (
    input  logic                         CLK50MHZ,
    input  logic                         RST,
    input  logic                         adc_trig,
    input  logic                         adc_miso,
    output logic                         adc_conv,
    output logic                         spi_sck,
    output logic                         adc_busy,
    output logic                         adc_done,
    output logic signed [ADC_DATA_W-1:0] adc_a,
    output logic signed [ADC_DATA_W-1:0] adc_b
);

    localparam logic [3:0] CONV_LAST = 4'(CONV_CYCLES - 1);

    adc_state_t                   r_state;
    adc_state_t                   w_state_next;
    logic [3:0]                   r_conv_cnt;
    logic [ADC_DATA_W-1:0]        r_sh_a;
    logic [ADC_DATA_W-1:0]        r_sh_b;
    logic signed [ADC_DATA_W-1:0] r_adc_a;
    logic signed [ADC_DATA_W-1:0] r_adc_b;
    logic                         w_shift_en;
    logic                         w_rise_tick;
    logic                         w_frame_end;
    logic [5:0]                   w_bit_idx;

    assign w_shift_en = (r_state == ST_SHIFT);

    adc_sck_gen #(
        .SCK_HALF(SCK_HALF)
    ) u_sck_gen (
        .i_clk       (CLK50MHZ),
        .i_rst       (RST),
        .i_en        (w_shift_en),
        .o_sck       (spi_sck),
        .o_rise_tick (w_rise_tick),
        .o_frame_end (w_frame_end),
        .o_bit_idx   (w_bit_idx)
    );

    // State register; reset aborts any capture in flight.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; triggers are only looked at in IDLE, so nothing is queued.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (adc_trig) w_state_next = ST_CONV;
            ST_CONV:  if (r_conv_cnt == CONV_LAST) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_frame_end) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        adc_conv = 1'b0;
        adc_busy = 1'b1;
        adc_done = 1'b0;
        unique case (r_state)
            ST_IDLE: adc_busy = 1'b0;
            ST_CONV: adc_conv = 1'b1;
            ST_DONE: adc_done = 1'b1;
            default: ;
        endcase
    end

    // Convert-strobe length counter, idle at zero outside CONV.
    always_ff @(posedge CLK50MHZ) begin
        if (RST || (r_state != ST_CONV) || (r_conv_cnt == CONV_LAST)) begin
            r_conv_cnt <= '0;
        end else begin
            r_conv_cnt <= r_conv_cnt + 4'd1;
        end
    end

    // Shift in MISO at each SCK rising tick, MSB first, skipping the high-Z slots.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
        end else if (w_rise_tick) begin
            if (bit_in_window(w_bit_idx, ADC_A_FIRST, ADC_A_LAST)) begin
                r_sh_a <= {r_sh_a[ADC_DATA_W-2:0], adc_miso};
            end
            if (bit_in_window(w_bit_idx, ADC_B_FIRST, ADC_B_LAST)) begin
                r_sh_b <= {r_sh_b[ADC_DATA_W-2:0], adc_miso};
            end
        end
    end

    // Results load on the edge entering DONE so they are valid alongside adc_done.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_adc_a <= '0;
            r_adc_b <= '0;
        end else if (w_shift_en && w_frame_end) begin
            r_adc_a <= $signed(r_sh_a);
            r_adc_b <= $signed(r_sh_b);
        end
    end

    assign adc_a = r_adc_a;
    assign adc_b = r_adc_b;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: a default-parameter instance and a fast
// instance (SCK_HALF=1, CONV_CYCLES=1), each with a serial ADC frame model.
module tb_adc_capture;

    logic               clk = 1'b0;
    logic               RST = 1'b1;

    logic               s_trig = 1'b0, s_miso = 1'b0;
    logic               s_conv, s_sck, s_busy, s_done;
    logic signed [13:0] s_a, s_b;

    logic               f_trig = 1'b0, f_miso = 1'b0;
    logic               f_conv, f_sck, f_busy, f_done;
    logic signed [13:0] f_a, f_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    adc_capture u_slow (
        .CLK50MHZ (clk),
        .RST      (RST),
        .adc_trig (s_trig),
        .adc_miso (s_miso),
        .adc_conv (s_conv),
        .spi_sck  (s_sck),
        .adc_busy (s_busy),
        .adc_done (s_done),
        .adc_a    (s_a),
        .adc_b    (s_b)
    );

    adc_capture #(
        .SCK_HALF    (1),
        .CONV_CYCLES (1)
    ) u_fast (
        .CLK50MHZ (clk),
        .RST      (RST),
        .adc_trig (f_trig),
        .adc_miso (f_miso),
        .adc_conv (f_conv),
        .spi_sck  (f_sck),
        .adc_busy (f_busy),
        .adc_done (f_done),
        .adc_a    (f_a),
        .adc_b    (f_b)
    );

    // ADC models: frame bit k sits at index 33-k; bit 0 is presented when the
    // convert strobe rises, each later bit after an SCK falling edge.
    logic [33:0] s_frame = '0, f_frame = '0;
    int          s_k = 0, f_k = 0;

    always @(posedge s_conv) begin s_k = 0; s_miso = s_frame[33]; end
    always @(negedge s_sck) begin
        s_k++;
        if (s_k < 34) s_miso = s_frame[33 - s_k];
    end
    always @(posedge f_conv) begin f_k = 0; f_miso = f_frame[33]; end
    always @(negedge f_sck) begin
        f_k++;
        if (f_k < 34) f_miso = f_frame[33 - f_k];
    end

    // Activity monitors.
    int  s_rises = 0, f_rises = 0, s_conv_cyc = 0, f_conv_cyc = 0, s_done_cnt = 0;
    time f_last_rise = 0, f_period = 0;
    always @(posedge s_sck) s_rises++;
    always @(posedge f_sck) begin
        f_rises++;
        f_period    = $time - f_last_rise;
        f_last_rise = $time;
    end
    always @(negedge clk) begin
        if (s_conv) s_conv_cyc++;
        if (f_conv) f_conv_cyc++;
        if (s_done) s_done_cnt++;
    end

    function automatic logic [33:0] mk_frame(input logic [13:0] a, input logic [13:0] b,
                                             input logic f);
        return {f, f, a, f, f, b, f, f};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One capture on the chosen instance: trig high for one cycle (cycle 0),
    // then count cycles until adc_done is seen.
    task automatic run_capture(input bit fast, input logic [13:0] a, input logic [13:0] b,
                               input logic fill, input int exp_lat, input int exp_conv,
                               input string tag);
        int          n;
        int          r0, c0;
        logic        dn;
        logic [13:0] ga, gb;
        if (fast) f_frame = mk_frame(a, b, fill);
        else      s_frame = mk_frame(a, b, fill);
        r0 = fast ? f_rises : s_rises;
        c0 = fast ? f_conv_cyc : s_conv_cyc;
        @(negedge clk);
        if (fast) f_trig = 1'b1; else s_trig = 1'b1;
        @(negedge clk);
        f_trig = 1'b0;
        s_trig = 1'b0;
        n  = 1;
        dn = fast ? f_done : s_done;
        while (!dn && n < 1000) begin
            @(negedge clk);
            n++;
            dn = fast ? f_done : s_done;
        end
        ga = fast ? f_a : s_a;
        gb = fast ? f_b : s_b;
        check_eq({tag, "_latency"}, n, exp_lat);
        check_eq({tag, "_adc_a"}, {18'd0, ga}, {18'd0, a});
        check_eq({tag, "_adc_b"}, {18'd0, gb}, {18'd0, b});
        check_eq({tag, "_busy_in_done"}, 32'(fast ? f_busy : s_busy), 32'd1);
        check_eq({tag, "_conv_cycles"}, (fast ? f_conv_cyc : s_conv_cyc) - c0, exp_conv);
        check_eq({tag, "_sck_rises"}, (fast ? f_rises : s_rises) - r0, 34);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 32'(fast ? f_done : s_done), 32'd0);
        check_eq({tag, "_idle_after"}, 32'(fast ? f_busy : s_busy), 32'd0);
    endtask

    int   idle_bad_s = 0, idle_bad_f = 0;
    int   n, dn_cnt, d1, d2, conv_pulses, d0;
    logic conv_prev;
    logic [13:0] a2;

    initial begin
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        check_eq("rst_adc_a", {18'd0, s_a}, 32'd0);
        check_eq("rst_adc_b", {18'd0, s_b}, 32'd0);
        check_eq("rst_outs", {28'd0, s_sck, s_conv, s_busy, s_done}, 32'd0);
        check_eq("rst_fast_outs", {28'd0, f_sck, f_conv, f_busy, f_done}, 32'd0);

        // Quiet period with no trigger.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s_sck | s_conv | s_busy | s_done) idle_bad_s++;
            if (f_sck | f_conv | f_busy | f_done) idle_bad_f++;
        end
        check_eq("idle_quiet_slow", idle_bad_s, 0);
        check_eq("idle_quiet_fast", idle_bad_f, 0);

        // Full-scale positive A, full-scale negative B.
        run_capture(1'b0, 14'h1FFF, 14'h2000, 1'b0, 207, 2, "maxmin");
        check_eq("maxmin_b_negative", 32'(s_b < 0), 32'd1);

        // Ignored frame slots driven high must not leak into the results.
        run_capture(1'b0, 14'h0155, 14'h2AAA, 1'b1, 207, 2, "fill_ones");

        // Trigger held high: back-to-back captures.
        dn_cnt = 0; d1 = 0; d2 = 0; conv_pulses = 0; conv_prev = 1'b0; a2 = '0;
        @(negedge clk);
        s_trig = 1'b1;
        for (int i = 1; i < 500; i++) begin
            @(negedge clk);
            if (s_conv && !conv_prev && i <= 415) conv_pulses++;
            conv_prev = s_conv;
            if (s_done) begin
                dn_cnt++;
                if (dn_cnt == 1) d1 = i;
                else if (dn_cnt == 2) begin d2 = i; a2 = s_a; end
            end
        end
        s_trig = 1'b0;
        check_eq("held_done_count", dn_cnt, 2);
        check_eq("held_first_done", d1, 207);
        check_eq("held_second_done", d2, 415);
        check_eq("held_conv_pulses", conv_pulses, 2);
        check_eq("held_second_a", {18'd0, a2}, 32'h0155);
        n = 0;
        while (s_busy && n < 1000) begin @(negedge clk); n++; end
        check_eq("held_drain_busy", 32'(s_busy), 32'd0);

        // Reset in the middle of the frame.
        s_frame = mk_frame(14'h2BCD, 14'h0F0F, 1'b0);
        @(negedge clk);
        s_trig = 1'b1;
        @(negedge clk);
        s_trig = 1'b0;
        n = 0;
        while (s_k != 10 && n < 1000) begin @(negedge clk); n++; end
        check_eq("abort_reached_k10", s_k, 10);
        check_eq("abort_busy_before", 32'(s_busy), 32'd1);
        d0 = s_done_cnt;
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check_eq("abort_adc_a", {18'd0, s_a}, 32'd0);
        check_eq("abort_adc_b", {18'd0, s_b}, 32'd0);
        check_eq("abort_outs", {28'd0, s_sck, s_conv, s_busy, s_done}, 32'd0);
        repeat (250) @(negedge clk);
        check_eq("abort_no_done", s_done_cnt - d0, 0);
        run_capture(1'b0, 14'h2BCD, 14'h0F0F, 1'b0, 207, 2, "after_abort");

        // Fastest SCK and shortest convert strobe.
        run_capture(1'b1, 14'h3FFF, 14'h0001, 1'b0, 70, 1, "fast");
        check_eq("fast_sck_period", 32'(f_period), 32'd40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
